singles_rr_merge: RTL and testbench
===================================

# singles_rr_merge

Round-robin merger that combines the per-module singles streams (first-word-fall-through outputs of the per-module receive data FIFOs) into one 128-bit stream toward the Ethernet transmit FIFO. It replaces fixed-priority selection, so a busy low-index module cannot starve the others. It drains and discards words from disabled modules, and keeps per-module forwarded and dropped word counters for the MicroBlaze status path.

## Interface
Parameters:
- NMODULES, 4, number of input streams
- LENGTH, 128, word width in bits
- CNT_W, 32, width of each counter

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  LENGTH*NMODULES  word of module k at [k*LENGTH +: LENGTH]
- in_valid  in  NMODULES  module k has a word (FWFT: data is valid while this is high)
- in_ready  out  NMODULES  word of module k is consumed this cycle when in_valid[k] & in_ready[k]
- enable  in  NMODULES  module k is forwarded when 1; drained and counted as dropped when 0
- out_data  out  LENGTH  merged word
- out_valid  out  1  out_data holds a word
- out_ready  in  1  downstream accepts (the FIFO's ~full)
- cnt_clear  in  1  synchronous clear of all counters
- fwd_count  out  CNT_W*NMODULES  words forwarded per module, at [k*CNT_W +: CNT_W]
- drop_count  out  CNT_W*NMODULES  words discarded per module

## Operation
- Output stage: a single register holds out_data/out_valid.
  - load = ~out_valid | out_ready.
  - On load with a grant: register the granted word and set out_valid=1.
  - On load with no grant: out_valid=0.
  - While out_valid & ~out_ready: out_data is held stable.
- Arbitration:
  - Candidates are modules with in_valid[k] & enable[k].
  - A pointer ptr (width clog2(NMODULES)) selects the highest-priority index.
  - The grant goes to the first candidate at ptr, ptr+1, … modulo NMODULES.
  - On each granted transfer (load & candidate exists), ptr becomes grant+1 modulo NMODULES.
  - Otherwise ptr holds.
  - At most one word is forwarded per cycle.
- in_ready[k], combinational:
  - enable[k]=1: in_ready[k] = load & (grant==k).
  - enable[k]=0: in_ready[k] = 1 (drain every cycle, independent of out_ready).
  - Never depends on in_valid[k] of the same module except through grant.
- Counters:
  - fwd_count[k] increments on in_valid[k] & enable[k] & in_ready[k].
  - drop_count[k] increments on in_valid[k] & ~enable[k].
  - Both wrap modulo 2^CNT_W.
- cnt_clear: all counters go to 0 next cycle; an event in the same cycle is not counted (clear wins).
- enable changes take effect the same cycle. A word already in the output register is delivered even if its module is then disabled.
- Word contents pass unmodified (flag bits 122/115 untouched).

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_data=0, ptr=0, all counters 0.
  - in_ready = ~enable while reset is held? No: in_ready=0 for all modules during reset.
- Reset is released synchronously inside the block through a 2-flop synchronizer on deassertion.
  - The first grant is possible on the 2nd clk edge after rst_n rises.
- Latency: input transfer at edge N gives out_valid=1 with that word after edge N.
- Throughput: 1 word/cycle while out_ready=1 and any candidate is valid.
  - With all NMODULES continuously valid and enabled, each module gets exactly 1 of every NMODULES transfers.
- Backpressure: out_ready=0 with out_valid=1 gives in_ready=0 for all enabled modules; ptr and out_data hold.
- Reset mid-transfer: the registered word is lost (out_valid→0 immediately); counters are cleared.
- No combinational path from out_ready to out_valid/out_data.
  - Combinational paths from out_ready to in_ready are permitted (FWFT read enable).

## Test plan
- Single stream: module 2 only valid with 5 words 0x…01–0x…05, out_ready=1 → out_valid high for 5 consecutive cycles, words in order, 1-cycle latency, fwd_count[2]=5, others 0.
- Fairness: all 4 modules continuously valid, enabled, out_ready=1 for 16 cycles after reset → grant order 0,1,2,3,0,1,2,3…; fwd_count = 4 each.
- Backpressure: words in flight, out_ready held 0 for 7 cycles → out_data stable, in_ready=0 for enabled modules, ptr unchanged; after release, ordering resumes with no loss or duplication.
- Disable drain: enable=4'b1011, module 2 valid for 10 cycles → in_ready[2]=1 each cycle, nothing from module 2 on out_data, drop_count[2]=10, fwd_count[2]=0.
- Counter edges:
  - fwd_count[0] preloaded by forcing to 32'hFFFF_FFFF, one transfer → 0.
  - cnt_clear asserted in the same cycle as a transfer → counter 0 next cycle.
- Async reset mid-stream: rst_n pulled low between edges while out_valid=1 → out_valid=0 without a clock edge; after release, the first output appears ≥2 edges later, starting from module 0.

Source files
------------

// File: rtl/singles_rr_merge.sv
// Round-robin merge of FWFT singles streams into one registered output; 1-cycle latency.
// Backpressure: out_ready=0 with a held word stalls enabled inputs; disabled inputs drain every cycle.
module singles_rr_merge #(
    parameter int NMODULES = 4,
    parameter int LENGTH   = 128,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [LENGTH*NMODULES-1:0]   in_data,
    input  logic [NMODULES-1:0]          in_valid,
    output logic [NMODULES-1:0]          in_ready,
    input  logic [NMODULES-1:0]          enable,
    output logic [LENGTH-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         cnt_clear,
    output logic [CNT_W*NMODULES-1:0]    fwd_count,
    output logic [CNT_W*NMODULES-1:0]    drop_count
);

    localparam int PTR_W = (NMODULES > 1) ? $clog2(NMODULES) : 1;

    logic [1:0]                    r_rst_sync;
    logic                          w_rst_int_n;
    logic [PTR_W-1:0]              r_ptr;
    logic                          r_out_vld;
    logic [LENGTH-1:0]             r_out_dat;
    logic [CNT_W*NMODULES-1:0]     r_fwd_cnt;
    logic [CNT_W*NMODULES-1:0]     r_drop_cnt;

    logic [NMODULES-1:0]           w_cand;
    logic                          w_gnt_vld;
    logic [PTR_W-1:0]              w_gnt_idx;
    logic [PTR_W-1:0]              w_scan;
    logic [PTR_W-1:0]              w_ptr_nxt;
    logic [LENGTH-1:0]             w_gnt_dat;
    logic                          w_load;
    logic                          w_xfer;

    // Assertion is immediate; deassertion is retimed so all state leaves reset on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_int_n = r_rst_sync[1];

    assign w_cand = in_valid & enable;
    assign w_load = ~r_out_vld | out_ready;
    assign w_xfer = w_load & w_gnt_vld;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int i = 0; i < NMODULES; i++) begin
            w_scan = PTR_W'((int'(r_ptr) + i) % NMODULES);
            if (!w_gnt_vld && w_cand[w_scan]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NMODULES - 1)) ? '0 : w_gnt_idx + PTR_W'(1);

    always_comb begin
        in_ready  = '0;
        w_gnt_dat = '0;
        for (int k = 0; k < NMODULES; k++) begin
            if (w_gnt_idx == PTR_W'(k)) begin
                w_gnt_dat = in_data[k*LENGTH +: LENGTH];
            end
            if (enable[k]) begin
                in_ready[k] = w_rst_int_n & w_xfer & (w_gnt_idx == PTR_W'(k));
            end else begin
                in_ready[k] = w_rst_int_n;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            r_out_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_out_dat <= w_gnt_dat;
                r_ptr     <= w_ptr_nxt;
            end
        end
    end

    // Clear has priority over any event in the same cycle.
    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            for (int k = 0; k < NMODULES; k++) begin
                if (cnt_clear) begin
                    r_fwd_cnt[k*CNT_W +: CNT_W]  <= '0;
                    r_drop_cnt[k*CNT_W +: CNT_W] <= '0;
                end else begin
                    if (in_valid[k] && enable[k] && in_ready[k]) begin
                        r_fwd_cnt[k*CNT_W +: CNT_W] <= r_fwd_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                    if (in_valid[k] && !enable[k]) begin
                        r_drop_cnt[k*CNT_W +: CNT_W] <= r_drop_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign out_valid  = r_out_vld;
    assign out_data   = r_out_dat;
    assign fwd_count  = r_fwd_cnt;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_singles_rr_merge.sv
// Directed bench for singles_rr_merge: vector table plus hand-written multi-cycle sequences.
module tb_singles_rr_merge;

    localparam int N = 4;
    localparam int L = 128;
    localparam int C = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [L*N-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     enable;
    logic [L-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             cnt_clear;
    logic [C*N-1:0]   fwd_count;
    logic [C*N-1:0]   drop_count;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    singles_rr_merge #(.NMODULES(N), .LENGTH(L), .CNT_W(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .enable     (enable),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cnt_clear  (cnt_clear),
        .fwd_count  (fwd_count),
        .drop_count (drop_count)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  en;
        logic        ordy;
        logic [7:0]  tag;
        logic [3:0]  e_rdy;
        logic        e_ovld;
        logic [15:0] e_dat;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [C-1:0] fwd(input int k);
        return fwd_count[k*C +: C];
    endfunction

    function automatic logic [C-1:0] drp(input int k);
        return drop_count[k*C +: C];
    endfunction

    task automatic set_lanes(input logic [7:0] tag);
        for (int k = 0; k < N; k++) in_data[k*L +: L] = 128'({tag, 8'(k)});
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        in_valid  = '0;
        cnt_clear = 1'b1;
        @(negedge clk);
        cnt_clear = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = '0;
        enable    = '1;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq [N];
        int         idx;
        int         n;
        logic       found;

        tbl[0]  = '{4'b0000, 4'b1111, 1'b1, 8'h01, 4'b0000, 1'b0, 16'h0000};
        tbl[1]  = '{4'b0100, 4'b1111, 1'b1, 8'h02, 4'b0100, 1'b0, 16'h0000};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 8'h03, 4'b1000, 1'b1, 16'h0202};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 8'h04, 4'b0000, 1'b1, 16'h0303};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 8'h05, 4'b0000, 1'b1, 16'h0303};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 8'h06, 4'b0001, 1'b1, 16'h0303};
        tbl[6]  = '{4'b1111, 4'b1101, 1'b1, 8'h07, 4'b0110, 1'b1, 16'h0600};
        tbl[7]  = '{4'b0000, 4'b0011, 1'b0, 8'h08, 4'b1100, 1'b1, 16'h0702};
        tbl[8]  = '{4'b0001, 4'b1111, 1'b1, 8'h09, 4'b0001, 1'b1, 16'h0702};
        tbl[9]  = '{4'b0000, 4'b1111, 1'b1, 8'h0A, 4'b0000, 1'b1, 16'h0900};
        tbl[10] = '{4'b0000, 4'b1111, 1'b0, 8'h0B, 4'b0000, 1'b0, 16'h0000};
        tbl[11] = '{4'b1000, 4'b1111, 1'b0, 8'h0C, 4'b1000, 1'b0, 16'h0000};
        tbl[12] = '{4'b0000, 4'b1111, 1'b1, 8'h0D, 4'b0000, 1'b1, 16'h0C03};
        tbl[13] = '{4'b0000, 4'b1111, 1'b1, 8'h0E, 4'b0000, 1'b0, 16'h0000};

        // Reset values with inputs that would otherwise drain
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        enable    = 4'b0000;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        set_lanes(8'hEE);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready), 128'(0));
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset out_data", out_data, 128'(0));
        chk("reset fwd_count", fwd_count, 128'(0));
        chk("reset drop_count", drop_count, 128'(0));

        in_valid = '0;
        enable   = '1;
        rst_n    = 1'b1;
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].vld;
            enable    = tbl[i].en;
            out_ready = tbl[i].ordy;
            set_lanes(tbl[i].tag);
            #1;
            chk($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(tbl[i].e_ovld));
            if (tbl[i].e_ovld) chk($sformatf("vec%0d out_data", i), out_data, 128'(tbl[i].e_dat));
        end
        chk("table fwd0", 128'(fwd(0)), 128'(2));
        chk("table fwd1", 128'(fwd(1)), 128'(0));
        chk("table fwd2", 128'(fwd(2)), 128'(2));
        chk("table fwd3", 128'(fwd(3)), 128'(2));
        chk("table drop1", 128'(drp(1)), 128'(1));
        chk("table drop2", 128'(drp(2)), 128'(0));

        // Single stream from module 2
        enable    = '1;
        out_ready = 1'b1;
        clear_pulse();
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            in_valid = (idx < 5) ? 4'b0100 : 4'b0000;
            in_data[2*L +: L] = 128'(idx + 1);
            #1;
            if (c >= 1 && c <= 5) begin
                chk($sformatf("single c%0d out_valid", c), 128'(out_valid), 128'(1));
                chk($sformatf("single c%0d out_data", c), out_data, 128'(c));
            end else begin
                chk($sformatf("single c%0d out_valid", c), 128'(out_valid), 128'(0));
            end
            if (in_valid[2] && in_ready[2]) idx++;
        end
        chk("single fwd0", 128'(fwd(0)), 128'(0));
        chk("single fwd1", 128'(fwd(1)), 128'(0));
        chk("single fwd2", 128'(fwd(2)), 128'(5));
        chk("single fwd3", 128'(fwd(3)), 128'(0));

        // Fairness from reset
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            in_valid = (c < 16) ? 4'b1111 : 4'b0000;
            set_lanes(8'(c));
            #1;
            if (c >= 1 && c <= 16) begin
                chk($sformatf("fair c%0d out_valid", c), 128'(out_valid), 128'(1));
                chk($sformatf("fair c%0d out_data", c), out_data,
                    128'({8'(c - 1), 8'((c - 1) % 4)}));
            end
            if (c == 17) chk("fair end out_valid", 128'(out_valid), 128'(0));
        end
        for (int k = 0; k < N; k++) chk($sformatf("fair fwd%0d", k), 128'(fwd(k)), 128'(4));

        // Backpressure: 7 stalled cycles in the middle of a round-robin stream
        for (int k = 0; k < N; k++) seq[k] = 8'd0;
        n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            in_valid  = (c < 14) ? 4'b1111 : 4'b0000;
            out_ready = !(c >= 3 && c < 10);
            for (int k = 0; k < N; k++) in_data[k*L +: L] = 128'({seq[k], 8'(k)});
            #1;
            if (c >= 3 && c < 10) begin
                chk($sformatf("stall c%0d in_ready", c), 128'(in_ready), 128'(0));
                chk($sformatf("stall c%0d out_valid", c), 128'(out_valid), 128'(1));
                chk($sformatf("stall c%0d out_data", c), out_data, 128'({8'(n / 4), 8'(n % 4)}));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp word%0d", n), out_data, 128'({8'(n / 4), 8'(n % 4)}));
                n++;
            end
            for (int k = 0; k < N; k++) if (in_valid[k] && in_ready[k]) seq[k]++;
        end
        chk("bp delivered count", 128'(n), 128'(7));
        out_ready = 1'b1;

        // Drain of a disabled module
        enable = 4'b1011;
        clear_pulse();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 4'b0100;
            set_lanes(8'hD0);
            #1;
            chk($sformatf("drain c%0d in_ready2", c), 128'(in_ready[2]), 128'(1));
            chk($sformatf("drain c%0d out_valid", c), 128'(out_valid), 128'(0));
        end
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("drain drop2", 128'(drp(2)), 128'(10));
        chk("drain fwd2", 128'(fwd(2)), 128'(0));

        // Counter wrap
        enable = '1;
        clear_pulse();
        force dut.r_fwd_cnt = {96'd0, 32'hFFFF_FFFF};
        #1;
        release dut.r_fwd_cnt;
        chk("wrap preload", 128'(fwd(0)), 128'(32'hFFFF_FFFF));
        in_valid = 4'b0001;
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("wrap fwd0", 128'(fwd(0)), 128'(0));

        // Clear in the same cycle as a transfer and a drop
        @(negedge clk);
        in_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre-clear fwd0", 128'(fwd(0)), 128'(2));
        cnt_clear = 1'b1;
        in_valid  = 4'b0011;
        enable    = 4'b1101;
        @(negedge clk);
        cnt_clear = 1'b0;
        in_valid  = 4'b0001;
        enable    = 4'b1111;
        #1;
        chk("clear-wins fwd0", 128'(fwd(0)), 128'(0));
        chk("clear-wins drop1", 128'(drp(1)), 128'(0));
        @(negedge clk);
        in_valid = '0;
        #1;
        chk("post-clear fwd0", 128'(fwd(0)), 128'(1));

        // Asynchronous reset while a word is held
        @(negedge clk);
        in_valid = 4'b1111;
        set_lanes(8'h55);
        @(negedge clk);
        #1;
        chk("pre-arst out_valid", 128'(out_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 128'(out_valid), 128'(0));
        chk("arst out_data", out_data, 128'(0));
        chk("arst fwd_count", fwd_count, 128'(0));
        chk("arst in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("arst 1 edge out_valid", 128'(out_valid), 128'(0));
        found = 1'b0;
        for (int w = 0; w < 8 && !found; w++) begin
            @(negedge clk);
            #1;
            if (out_valid) found = 1'b1;
        end
        chk("arst first output seen", 128'(found), 128'(1));
        chk("arst first from module 0", 128'(out_data[7:0]), 128'(0));

        in_valid = '0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
